ram8_chip: RTL and testbench

//  Eight-word register memory: the stage directly downstream of dmux_8way_gate.
//  - One dmux_8way_gate instance fans the write strobe out to eight word registers.
//  - A mux_8way16-style read path selects the output word.
//  - Adds a self-timed clear sequencer that zeroes the array one word per cycle.
//  - Building block for ram64 and larger Hack memories.

---
 rtl/ram8_chip.sv | 124 ++++++++++++
 tb/tb_ram8_chip.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ram8_chip.sv
// ram8_chip: eight-word register memory with a dmux write fan-out, mux read path and
// a self-timed clear sequencer. Define RAM8_PARITY_EN to add per-word parity checking.
module dmux_8way_gate (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);
  assign {h, g, f, e, d, c, b, a} = {7'b0, in} << sel;
endmodule

module ram8_chip #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic [2:0]       address,
  input  logic             load,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy
`ifdef RAM8_PARITY_EN
  ,
  input  logic             par_inject,
  output logic             parity_err
`endif
);
  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [WIDTH-1:0] mem [8];
  logic             we;
  logic [2:0]       wsel;
  logic [WIDTH-1:0] wdata;
  logic [7:0]       wen;

  // While busy the sequencer owns the write port; a load coinciding with clear is dropped.
  assign we    = busy | (load & ~clear);
  assign wsel  = busy ? ptr : address;
  assign wdata = busy ? CLEAR_VALUE : in;

  dmux_8way_gate u_dmux (
    .in (we),
    .sel(wsel),
    .a  (wen[0]),
    .b  (wen[1]),
    .c  (wen[2]),
    .d  (wen[3]),
    .e  (wen[4]),
    .f  (wen[5]),
    .g  (wen[6]),
    .h  (wen[7])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wen[i]) mem[i] <= wdata;
      end
    end
  end

  assign out = mem[address];

  // Clear sequencer: eight write edges, ptr wraps back to 0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 3'd0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear) begin
            state <= CLEAR;
            ptr   <= 3'd0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          ptr <= ptr + 3'd1;
          if (ptr == 3'd7) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RAM8_PARITY_EN
  logic [7:0] par;
  logic       pdata;

  assign pdata = busy ? (^CLEAR_VALUE) : ((^in) ^ par_inject);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 8'd0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (wen[i]) par[i] <= pdata;
      end
    end
  end

  assign parity_err = (^out) ^ par[address];
`endif
endmodule

// File: tb/tb_ram8_chip.sv
// Self-checking bench for ram8_chip: vector table, hand-written corner sequences and
// randomized traffic against a word-array reference model.
module tb_ram8_chip;
  localparam logic [15:0] CV = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] din = '0;
  logic [2:0]  address = '0;
  logic [15:0] dout;
  logic        busy;
`ifdef RAM8_PARITY_EN
  logic        par_inject = 1'b0;
  logic        parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram8_chip #(.WIDTH(16), .CLEAR_VALUE(CV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .address   (address),
    .load      (load),
    .clear     (clear),
    .out       (dout),
    .busy      (busy)
`ifdef RAM8_PARITY_EN
    ,
    .par_inject(par_inject),
    .parity_err(parity_err)
`endif
  );

  // Reference model: word array, per-word "parity was injected" flag, words left to clear.
  logic [15:0] m_mem [8];
  logic        m_err [8];
  int          m_clr;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_err[i] = 1'b0;
    end
    m_clr = 0;
  endtask

  task automatic model_edge(input logic ld, input logic cl, input logic [2:0] a,
                            input logic [15:0] d, input logic inj);
    if (m_clr > 0) begin
      m_mem[8 - m_clr] = CV;
      m_err[8 - m_clr] = 1'b0;
      m_clr--;
    end else if (cl) begin
      m_clr = 8;
    end else if (ld) begin
      m_mem[a] = d;
      m_err[a] = inj;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive at negedge, apply one rising edge, return at the following negedge.
  task automatic step(input logic ld, input logic cl, input logic [2:0] a,
                      input logic [15:0] d, input logic inj);
    load = ld;
    clear = cl;
    address = a;
    din = d;
`ifdef RAM8_PARITY_EN
    par_inject = inj;
`endif
    @(posedge clk);
    model_edge(ld, cl, a, d, inj);
    @(negedge clk);
  endtask

  typedef struct {
    logic        ld;
    logic        cl;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] exp_out;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [15:0] v;

    for (int k = 0; k < 8; k++) begin
      v = 16'(16'h1111 * (k + 1));
      tbl.push_back('{1'b1, 1'b0, 3'(k), v, v, 1'b0});
    end
    for (int k = 0; k < 8; k++) begin
      v = 16'(16'h1111 * (k + 1));
      tbl.push_back('{1'b0, 1'b0, 3'(k), 16'hFFFF, v, 1'b0});
    end
    tbl.push_back('{1'b1, 1'b0, 3'd3, 16'hABCD, 16'hABCD, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd2, 16'h0000, 16'h3333, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd4, 16'h0000, 16'h5555, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 3'd3, 16'h0000, 16'hABCD, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3'd7, 16'h0000, 16'h8888, 1'b1});
    for (int k = 0; k < 7; k++) tbl.push_back('{1'b0, 1'b0, 3'd7, 16'h0000, 16'h8888, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 3'd7, 16'h0000, CV, 1'b0});
    for (int k = 0; k < 8; k++) tbl.push_back('{1'b0, 1'b0, 3'(k), 16'h0000, CV, 1'b0});

    // Reset state
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("reset_out[%0d]", a), 32'(dout), 32'h0);
    end
    chk("reset_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: writes, readback, isolation, clear timing
    foreach (tbl[i]) begin
      step(tbl[i].ld, tbl[i].cl, tbl[i].a, tbl[i].d, 1'b0);
      chk($sformatf("tbl%0d_out", i), 32'(dout), 32'(tbl[i].exp_out));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
    end

    // Load in the clear cycle and during busy is dropped; first idle load lands
    step(1'b1, 1'b0, 3'd5, 16'h1234, 1'b0);
    chk("pre_clear_w5", 32'(dout), 32'h1234);
    step(1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0);
    chk("clr_accept_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, 3'd5, 16'hBEEF, 1'b0);
      chk($sformatf("clr_busy_c%0d", i + 2), 32'(busy), 32'h1);
    end
    step(1'b1, 1'b0, 3'd5, 16'hBEEF, 1'b0);
    chk("clr_done_busy", 32'(busy), 32'h0);
    chk("clr_done_w5", 32'(dout), 32'(CV));
    step(1'b1, 1'b0, 3'd5, 16'hBEEF, 1'b0);
    chk("first_idle_load_w5", 32'(dout), 32'hBEEF);

    // Asynchronous reset in the 4th busy cycle
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 3'(k), 16'hA000 | 16'(k), 1'b0);
    step(1'b0, 1'b1, 3'd7, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'd7, 16'h0, 1'b0);
    chk("mid_clear_busy", 32'(busy), 32'h1);
    chk("mid_clear_w7", 32'(dout), 32'hA007);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #0.5;
      chk($sformatf("rst_mid_out[%0d]", a), 32'(dout), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 3'd6, 16'h6666, 1'b0);
    chk("post_rst_w6", 32'(dout), 32'h6666);
    chk("post_rst_busy", 32'(busy), 32'h0);

`ifdef RAM8_PARITY_EN
    step(1'b1, 1'b0, 3'd2, 16'h0001, 1'b1);
    chk("par_err_a2", 32'(parity_err), 32'h1);
    address = 3'd1;
    #1;
    chk("par_ok_a1", 32'(parity_err), 32'h0);
    @(negedge clk);
    step(1'b0, 1'b1, 3'd0, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("par_after_clear[%0d]", a), 32'(parity_err), 32'h0);
    end
    @(negedge clk);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        ld, cl, inj;
      logic [2:0]  a;
      logic [15:0] d;
      ld  = 1'($urandom_range(0, 1));
      cl  = ($urandom_range(0, 24) == 0);
      inj = ($urandom_range(0, 3) == 0);
      a   = 3'($urandom_range(0, 7));
      d   = 16'($urandom);
      step(ld, cl, a, d, inj);
      chk($sformatf("rnd%0d_out", i), 32'(dout), 32'(m_mem[a]));
      chk($sformatf("rnd%0d_busy", i), 32'(busy), 32'(m_clr > 0));
`ifdef RAM8_PARITY_EN
      chk($sformatf("rnd%0d_par", i), 32'(parity_err), 32'(m_err[a]));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
